// File: rtl/tile_bl_wl_config_loader.sv
// Memory-bank configuration loader for one tile.
// A serial bitstream arrives under a valid/ready handshake and is packed into
// BL_WIDTH-bit frames. Each completed frame is presented on bl while one word
// line is pulsed for WL_PULSE cycles, followed by one hold cycle with all word
// lines low. Rows are written 0..WL_WIDTH-1, then the loader parks in DONE.
// BL_WIDTH must be at least 2. WL_PULSE must be in the range 1..15.
module tile_bl_wl_config_loader #(
  parameter int BL_WIDTH = 72,
  parameter int WL_WIDTH = 72,
  parameter int WL_PULSE = 2,
  localparam int ROW_W = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1,
  localparam int CNT_W = (BL_WIDTH > 1) ? $clog2(BL_WIDTH) : 1
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic                din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_WIDTH-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic [ROW_W-1:0]    row
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Terminal counter values, sized to the counters they are compared with.
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BL_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(WL_WIDTH - 1);
  localparam logic [3:0]       PULSE_LAST = 4'(WL_PULSE - 1);

  // Registered state.
  state_t              r_state;
  logic [BL_WIDTH-2:0] r_shift;      // partial frame, oldest bit at [0]
  logic [BL_WIDTH-1:0] r_bl;
  logic [WL_WIDTH-1:0] r_wl;
  logic [ROW_W-1:0]    r_row;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [3:0]          r_pulse;
  logic                r_busy;
  logic                r_done;
  logic                r_din_ready;

  // Next-state values.
  state_t              w_state_next;
  logic [BL_WIDTH-2:0] w_shift_next;
  logic [BL_WIDTH-1:0] w_bl_next;
  logic [WL_WIDTH-1:0] w_wl_next;
  logic [ROW_W-1:0]    w_row_next;
  logic [CNT_W-1:0]    w_bitcnt_next;
  logic [3:0]          w_pulse_next;
  logic                w_busy_next;
  logic                w_done_next;
  logic                w_din_ready_next;

  // Combinational helpers.
  logic                w_accept;
  logic [BL_WIDTH-1:0] w_frame;
  logic [WL_WIDTH-1:0] w_wl_onehot;
  logic                w_last_bit;
  logic                w_last_row;
  logic                w_last_pulse;

  // din_ready comes straight from a register, so acceptance never loops
  // back through din_valid into the upstream source.
  assign w_accept     = r_din_ready & din_valid;

  // Shifting right places the first accepted bit at bit 0 once the frame
  // is complete; the incoming bit becomes the top bit of the frame.
  assign w_frame      = {din, r_shift};

  assign w_wl_onehot  = WL_WIDTH'(1) << r_row;
  assign w_last_bit   = (r_bitcnt == BIT_LAST);
  assign w_last_row   = (r_row == ROW_LAST);
  assign w_last_pulse = (r_pulse == PULSE_LAST);

  // Next-state and datapath decode; every target defaults to holding.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bl_next     = r_bl;
    w_wl_next     = r_wl;
    w_row_next    = r_row;
    w_bitcnt_next = r_bitcnt;
    w_pulse_next  = r_pulse;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next  = S_SHIFT;
          w_row_next    = '0;
          w_bitcnt_next = '0;
        end
      end

      S_SHIFT: begin
        if (w_accept) begin
          w_shift_next = w_frame[BL_WIDTH-1:1];
          if (w_last_bit) begin
            // Frame complete: bit lines and the row's word line go up
            // together, so bl is already settled for the whole pulse.
            w_bl_next     = w_frame;
            w_wl_next     = w_wl_onehot;
            w_pulse_next  = '0;
            w_bitcnt_next = '0;
            w_state_next  = S_WRITE;
          end else begin
            w_bitcnt_next = r_bitcnt + CNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        if (w_last_pulse) begin
          w_wl_next    = '0;
          w_state_next = S_HOLD;
        end else begin
          w_pulse_next = r_pulse + 4'd1;
        end
      end

      S_HOLD: begin
        // bl stays put for one cycle after the word line drops.
        if (w_last_row) begin
          w_state_next = S_DONE;
        end else begin
          w_row_next    = r_row + ROW_W'(1);
          w_bitcnt_next = '0;
          w_state_next  = S_SHIFT;
        end
      end

      S_DONE: begin
        if (start) begin
          w_state_next  = S_SHIFT;
          w_row_next    = '0;
          w_bitcnt_next = '0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_wl_next    = '0;
      end
    endcase
  end

  // Status flags are decoded from the next state so they are registered and
  // change on the very edge that makes the state transition.
  always_comb begin
    w_busy_next      = (w_state_next == S_SHIFT) ||
                       (w_state_next == S_WRITE) ||
                       (w_state_next == S_HOLD);
    w_done_next      = (w_state_next == S_DONE);
    w_din_ready_next = (w_state_next == S_SHIFT);
  end

  // FSM state and status flag registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_din_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_din_ready <= w_din_ready_next;
    end
  end

  // Row, bit and pulse counters.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_row    <= '0;
      r_bitcnt <= '0;
      r_pulse  <= '0;
    end else begin
      r_row    <= w_row_next;
      r_bitcnt <= w_bitcnt_next;
      r_pulse  <= w_pulse_next;
    end
  end

  // Frame assembly and the bit-line / word-line output registers; reset
  // drops every word line immediately, abandoning any write in progress.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_shift <= '0;
      r_bl    <= '0;
      r_wl    <= '0;
    end else begin
      r_shift <= w_shift_next;
      r_bl    <= w_bl_next;
      r_wl    <= w_wl_next;
    end
  end

  assign din_ready = r_din_ready;
  assign bl        = r_bl;
  assign wl        = r_wl;
  assign busy      = r_busy;
  assign done      = r_done;
  assign row       = r_row;

endmodule
